inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Instruction fetch front end. It holds the program counter, reads one word
// per cycle from a combinational instruction memory and queues {pc, inst}
// pairs in a two-entry buffer that decode drains with a valid/ready handshake.
// A branch redirect flushes the buffer and reloads the pc. A halt request
// stops new fetches while already-queued entries keep draining.
//
// Ports
//   clk           : single clock, all state changes on its rising edge
//   rst           : synchronous active-high reset
//   ce            : instruction memory read enable
//   inst_addr     : word-aligned byte address presented to memory (== pc)
//   inst          : instruction word returned by memory in the same cycle
//   halt          : level request to stop issuing new fetches
//   branch_flag   : single-cycle redirect request
//   branch_target : redirect byte address (low two bits dropped)
//   if_valid      : head-of-buffer entry valid toward decode
//   if_ready      : decode accepts the head entry this cycle
//   if_inst       : head-entry instruction
//   if_pc         : head-entry byte address
// ---------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ce,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    input  logic        halt,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Fetches are always word aligned, even if a misaligned reset pc is given.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fifo_pc   [2];
    logic [31:0] fifo_inst [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        deq;

    assign inst_addr = pc;

    // While reset is asserted the buffer may still hold stale entries from
    // before the reset edge; they are masked so nothing leaks to decode.
    assign if_valid = !rst && (count != 2'd0);
    assign deq      = if_valid && if_ready;
    assign if_pc    = rst ? 32'h0 : fifo_pc[rd_ptr];
    assign if_inst  = rst ? 32'h0 : fifo_inst[rd_ptr];

    // A full buffer may still fetch when the head leaves in the same cycle,
    // which keeps streaming at one word per cycle without a bubble.
    assign ce = !rst && (state == RUN) && !halt && !branch_flag &&
                ((count != 2'd2) || deq);

    // Control state, pc and buffer. A redirect takes priority over the
    // handshake: it discards everything queued, including a head being
    // accepted this cycle, and fetches nothing until the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC_ALIGNED;
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_pc[0]   <= 32'h0;
            fifo_pc[1]   <= 32'h0;
            fifo_inst[0] <= 32'h0;
            fifo_inst[1] <= 32'h0;
        end else begin
            case (state)
                IDLE:    state <= halt ? HALTED : RUN;
                RUN:     state <= halt ? HALTED : RUN;
                HALTED:  state <= halt ? HALTED : RUN;
                default: state <= IDLE;
            endcase

            if (branch_flag) begin
                pc     <= branch_target & 32'hFFFF_FFFC;
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (ce) begin
                    fifo_pc[wr_ptr]   <= pc;
                    fifo_inst[wr_ptr] <= inst;
                    wr_ptr            <= ~wr_ptr;
                    pc                <= pc + 32'd4;
                end
                if (deq) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({ce, deq})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//
// Directed bench for inst_fetch_ctrl. Two instances share all inputs: one with
// the default reset pc and one that starts just below the top of the address
// space so the pc wrap can be observed. Each modelled memory returns
// 32'h1000_0000 | address. Inputs change 1 time unit after a rising edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        if_ready;

    logic        ce;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    logic        w_ce;
    logic [31:0] w_inst_addr;
    logic [31:0] w_inst;
    logic        w_if_valid;
    logic [31:0] w_if_inst;
    logic [31:0] w_if_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Combinational instruction memories.
    assign inst   = 32'h1000_0000 | inst_addr;
    assign w_inst = 32'h1000_0000 | w_inst_addr;

    inst_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .ce(ce), .inst_addr(inst_addr), .inst(inst),
        .halt(halt), .branch_flag(branch_flag), .branch_target(branch_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc)
    );

    inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .ce(w_ce), .inst_addr(w_inst_addr), .inst(w_inst),
        .halt(halt), .branch_flag(branch_flag), .branch_target(branch_target),
        .if_valid(w_if_valid), .if_ready(if_ready), .if_inst(w_if_inst), .if_pc(w_if_pc)
    );

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply a two-cycle reset and leave the design in its post-reset cycle.
    task automatic do_reset();
        rst = 1'b1; halt = 1'b0; branch_flag = 1'b0; branch_target = 32'h0; if_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Outputs during reset and in the single IDLE cycle that follows.
    task automatic test_reset();
        rst = 1'b1; halt = 1'b0; branch_flag = 1'b0; branch_target = 32'h0; if_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        n_checks++; if (ce !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ce: got %b want 0", ce); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b want 0", if_valid); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_if_pc: got %h want 0", if_pc); end
        n_checks++; if (if_inst !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_if_inst: got %h want 0", if_inst); end
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_addr: got %h want 0", inst_addr); end
        n_checks++; if (w_inst_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("[TB] FAIL rst_wrap_addr: got %h want fffffff8", w_inst_addr); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ce !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_ce: got %b want 0", ce); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_valid: got %b want 0", if_valid); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL idle_if_pc: got %h want 0", if_pc); end
        n_checks++; if (if_inst !== 32'h0) begin n_fail++; $display("[TB] FAIL idle_if_inst: got %h want 0", if_inst); end
    endtask

    // Continuous streaming with decode always ready: one word per cycle.
    task automatic test_stream();
        logic [31:0] exp_pc;
        if_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++; if (ce !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_first_ce: got %b want 1", ce); end
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL stream_first_addr: got %h want 0", inst_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_first_valid: got %b want 0", if_valid); end
        for (int k = 0; k < 5; k++) begin
            exp_pc = 32'h4 * k;
            next_cycle();
            @(negedge clk);
            n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_valid[%0d]: got %b want 1", k, if_valid); end
            n_checks++; if (if_pc !== exp_pc) begin n_fail++; $display("[TB] FAIL stream_pc[%0d]: got %h want %h", k, if_pc, exp_pc); end
            n_checks++; if (if_inst !== (32'h1000_0000 | exp_pc)) begin n_fail++; $display("[TB] FAIL stream_inst[%0d]: got %h want %h", k, if_inst, 32'h1000_0000 | exp_pc); end
            n_checks++; if (ce !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_ce[%0d]: got %b want 1", k, ce); end
        end
    endtask

    // Decode stalled from reset: exactly two fetches, then lossless release.
    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        next_cycle();
        @(negedge clk);
        n_checks++; if (ce !== 1'b1 || inst_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL bp_fetch0: got ce=%b addr=%h want ce=1 addr=0", ce, inst_addr); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (ce !== 1'b1 || inst_addr !== 32'h4) begin n_fail++; $display("[TB] FAIL bp_fetch4: got ce=%b addr=%h want ce=1 addr=4", ce, inst_addr); end
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            @(negedge clk);
            n_checks++; if (ce !== 1'b0 || inst_addr !== 32'h8) begin n_fail++; $display("[TB] FAIL bp_full[%0d]: got ce=%b addr=%h want ce=0 addr=8", k, ce, inst_addr); end
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL bp_head[%0d]: got valid=%b pc=%h want valid=1 pc=0", k, if_valid, if_pc); end
        end
        next_cycle();
        if_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (ce !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_full_deq_ce: got %b want 1", ce); end
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'h4 * k;
            if (k > 0) begin
                next_cycle();
                @(negedge clk);
            end
            n_checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin n_fail++; $display("[TB] FAIL bp_drain[%0d]: got valid=%b pc=%h want valid=1 pc=%h", k, if_valid, if_pc, exp_pc); end
        end
    endtask

    // Redirect with a full buffer and a concurrent accept: everything flushed.
    task automatic test_branch();
        do_reset();
        next_cycle();
        next_cycle();
        next_cycle();
        branch_flag = 1'b1; branch_target = 32'h0000_0043; if_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (ce !== 1'b0) begin n_fail++; $display("[TB] FAIL br_ce: got %b want 0", ce); end
        next_cycle();
        branch_flag = 1'b0; branch_target = 32'h0;
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL br_flush_valid: got %b want 0", if_valid); end
        n_checks++; if (inst_addr !== 32'h40) begin n_fail++; $display("[TB] FAIL br_addr: got %h want 40", inst_addr); end
        n_checks++; if (ce !== 1'b1) begin n_fail++; $display("[TB] FAIL br_refetch_ce: got %b want 1", ce); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin n_fail++; $display("[TB] FAIL br_head: got valid=%b pc=%h want valid=1 pc=40", if_valid, if_pc); end
        n_checks++; if (if_inst !== 32'h1000_0040) begin n_fail++; $display("[TB] FAIL br_inst: got %h want 10000040", if_inst); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (if_pc !== 32'h44) begin n_fail++; $display("[TB] FAIL br_next: got %h want 44", if_pc); end
    endtask

    // Halt for three cycles with two entries queued: drain, freeze, resume.
    task automatic test_halt();
        next_cycle();
        if_ready = 1'b0;
        next_cycle();
        halt = 1'b1; if_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (ce !== 1'b0 || if_pc !== 32'h48 || if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_h1: got ce=%b valid=%b pc=%h want ce=0 valid=1 pc=48", ce, if_valid, if_pc); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (ce !== 1'b0 || if_pc !== 32'h4C || if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_h2: got ce=%b valid=%b pc=%h want ce=0 valid=1 pc=4c", ce, if_valid, if_pc); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (ce !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_h3: got ce=%b valid=%b want ce=0 valid=0", ce, if_valid); end
        n_checks++; if (inst_addr !== 32'h50) begin n_fail++; $display("[TB] FAIL halt_pc_frozen: got %h want 50", inst_addr); end
        next_cycle();
        halt = 1'b0;
        @(negedge clk);
        n_checks++; if (ce !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_release_ce: got %b want 0", ce); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (ce !== 1'b1 || inst_addr !== 32'h50) begin n_fail++; $display("[TB] FAIL halt_resume: got ce=%b addr=%h want ce=1 addr=50", ce, inst_addr); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h50 || if_inst !== 32'h1000_0050) begin n_fail++; $display("[TB] FAIL halt_resume_head: got valid=%b pc=%h inst=%h want 1 50 10000050", if_valid, if_pc, if_inst); end
    endtask

    // Reset and redirect together with a full buffer: reset wins.
    task automatic test_reset_branch();
        next_cycle();
        if_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1; branch_flag = 1'b1; branch_target = 32'h0000_0100;
        @(negedge clk);
        n_checks++; if (ce !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rb_during: got ce=%b valid=%b pc=%h want 0 0 0", ce, if_valid, if_pc); end
        next_cycle();
        rst = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
        @(negedge clk);
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL rb_pc: got %h want 0", inst_addr); end
        n_checks++; if (ce !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_idle: got ce=%b valid=%b want 0 0", ce, if_valid); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (ce !== 1'b1 || inst_addr !== 32'h0 || if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_run: got ce=%b addr=%h valid=%b want 1 0 0", ce, inst_addr, if_valid); end
    endtask

    // Top-of-address-space reset pc wraps to zero.
    task automatic test_wrap();
        logic [31:0] exp_pc;
        do_reset();
        if_ready = 1'b1;
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'hFFFF_FFF8 + 32'h4 * k;
            next_cycle();
            @(negedge clk);
            n_checks++; if (w_if_valid !== 1'b1 || w_if_pc !== exp_pc) begin n_fail++; $display("[TB] FAIL wrap_pc[%0d]: got valid=%b pc=%h want valid=1 pc=%h", k, w_if_valid, w_if_pc, exp_pc); end
            n_checks++; if (w_if_inst !== (32'h1000_0000 | exp_pc)) begin n_fail++; $display("[TB] FAIL wrap_inst[%0d]: got %h want %h", k, w_if_inst, 32'h1000_0000 | exp_pc); end
        end
        n_checks++; if (w_inst_addr !== 32'h4) begin n_fail++; $display("[TB] FAIL wrap_addr: got %h want 4", w_inst_addr); end
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; branch_flag = 1'b0; branch_target = 32'h0; if_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_halt();
        test_reset_branch();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
